// File: rtl/sfif_cpl_gen.sv
// CplD header generator: splits one memory read into MPS-aligned completions.
// First header is valid two cycles after accept, with one bubble after each handshake; holds stable under cpl_ready backpressure.
module sfif_cpl_gen #(
    parameter int MPS_DW = 32
) (
    input  logic        clk_125,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_tag,
    input  logic [15:0] req_rid,
    input  logic [9:0]  req_addr,
    input  logic [9:0]  req_len,
    input  logic [15:0] cfg_cid,
    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [95:0] cpl_hdr,
    output logic [9:0]  cpl_len,
    output logic        cpl_last
);
    typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

    typedef struct packed {
        logic [31:0] dw0;
        logic [15:0] cid;
        logic [2:0]  status;
        logic        bcm;
        logic [11:0] bc;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic        rsvd;
        logic [6:0]  lower_addr;
    } hdr_t;

    state_t      state, state_nxt;
    logic [4:0]  tag;
    logic [15:0] rid;
    logic [15:0] cid;
    logic [9:0]  cur_addr;
    logic [10:0] rem;
    logic [8:0]  this_len;

    logic        accept;
    logic        cpl_hs;
    logic [7:0]  mps_off;
    logic [8:0]  room;
    logic [8:0]  len_calc;
    hdr_t        hdr_nxt;

    assign accept = req_valid & req_ready;
    assign cpl_hs = cpl_valid & cpl_ready;

    always_ff @(posedge clk_125) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    state_nxt = SEND;
            SEND:    if (cpl_hs) state_nxt = cpl_last ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        cpl_valid = (state == SEND);
    end

    // Room left before the next naturally aligned MPS boundary; never exceeds 256.
    always_comb begin
        mps_off  = cur_addr[7:0] & 8'(MPS_DW - 1);
        room     = 9'(MPS_DW) - {1'b0, mps_off};
        len_calc = (rem < {2'b00, room}) ? rem[8:0] : room;
    end

    // Byte count is the remaining bytes of the whole request; 4096 wraps to 0.
    always_comb begin
        hdr_nxt            = '0;
        hdr_nxt.dw0        = 32'h4A00_0000 | {23'd0, len_calc};
        hdr_nxt.cid        = cid;
        hdr_nxt.status     = 3'b000;
        hdr_nxt.bcm        = 1'b0;
        hdr_nxt.bc         = {rem[9:0], 2'b00};
        hdr_nxt.rid        = rid;
        hdr_nxt.tag        = {3'b000, tag};
        hdr_nxt.rsvd       = 1'b0;
        hdr_nxt.lower_addr = {cur_addr[4:0], 2'b00};
    end

    always_ff @(posedge clk_125) begin
        if (rst) begin
            tag      <= '0;
            rid      <= '0;
            cid      <= '0;
            cur_addr <= '0;
            rem      <= '0;
            this_len <= '0;
            cpl_hdr  <= '0;
            cpl_len  <= '0;
            cpl_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tag      <= req_tag;
                        rid      <= req_rid;
                        cid      <= cfg_cid;
                        cur_addr <= req_addr;
                        rem      <= (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
                    end
                end
                CALC: begin
                    this_len <= len_calc;
                    cpl_len  <= {1'b0, len_calc};
                    cpl_last <= (rem == {2'b00, len_calc});
                    cpl_hdr  <= hdr_nxt;
                end
                SEND: begin
                    if (cpl_hs) begin
                        rem      <= rem - {2'b00, this_len};
                        cur_addr <= cur_addr + {1'b0, this_len};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfif_cpl_gen.sv
// Scoreboard bench for sfif_cpl_gen: directed test-plan cases plus randomized requests.
module tb_sfif_cpl_gen;
    localparam int MPS = 32;

    logic        clk_125 = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_tag = '0;
    logic [15:0] req_rid = '0;
    logic [9:0]  req_addr = '0;
    logic [9:0]  req_len = '0;
    logic [15:0] cfg_cid = '0;
    logic        cpl_valid;
    logic        cpl_ready = 1'b1;
    logic [95:0] cpl_hdr;
    logic [9:0]  cpl_len;
    logic        cpl_last;

    sfif_cpl_gen #(.MPS_DW(MPS)) dut (
        .clk_125   (clk_125),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_rid   (req_rid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .cfg_cid   (cfg_cid),
        .cpl_valid (cpl_valid),
        .cpl_ready (cpl_ready),
        .cpl_hdr   (cpl_hdr),
        .cpl_len   (cpl_len),
        .cpl_last  (cpl_last)
    );

    always #4 clk_125 = ~clk_125;

    typedef struct packed {
        logic [95:0] hdr;
        logic [9:0]  len;
        logic        last;
    } cpl_t;

    cpl_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    function automatic void check(string name, logic [95:0] act, logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: walk the read in chunks that stop at every MPS boundary.
    task automatic model_req(input logic [9:0] addr, input logic [9:0] len, input logic [4:0] tag,
                             input logic [15:0] rid, input logic [15:0] cid);
        int   rem_dw;
        int   a;
        int   l;
        int   bc;
        cpl_t c;
        rem_dw = (len == 10'd0) ? 1024 : int'(len);
        a = int'(addr);
        while (rem_dw > 0) begin
            l = MPS - (a % MPS);
            if (l > rem_dw) l = rem_dw;
            bc = (rem_dw * 4) % 4096;
            c.hdr  = {32'h4A00_0000 + 32'(l), cid, 4'b0000, 12'(bc),
                      rid, 3'b000, tag, 1'b0, 7'((a * 4) % 128)};
            c.len  = 10'(l);
            c.last = (rem_dw == l);
            exp_q.push_back(c);
            rem_dw -= l;
            a = (a + l) % 1024;
        end
    endtask

    // Issues one request; returns at the negedge of cycle N+2 after the accept edge N.
    task automatic send_req(input logic [9:0] addr, input logic [9:0] len, input logic [4:0] tag,
                            input logic [15:0] rid, input logic [15:0] cid);
        int t;
        @(posedge clk_125); #1;
        req_addr  = addr;
        req_len   = len;
        req_tag   = tag;
        req_rid   = rid;
        cfg_cid   = cid;
        req_valid = 1'b1;
        model_req(addr, len, tag, rid, cid);
        t = 0;
        @(negedge clk_125);
        while (!req_ready && t < 5000) begin
            @(negedge clk_125);
            t++;
        end
        if (!req_ready) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk_125); #1;
        req_valid = 1'b0;
        cfg_cid   = 16'($urandom);
        @(negedge clk_125);
        check("lat_calc_valid", cpl_valid, 0);
        check("lat_calc_req_ready", req_ready, 0);
        @(negedge clk_125);
        check("lat_send_valid", cpl_valid, 1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && req_ready) && t < 5000) begin
            @(negedge clk_125);
            t++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk_125); #1;
            case (rdy_mode)
                0:       cpl_ready = 1'b1;
                1:       cpl_ready = ($urandom % 3) != 0;
                default: cpl_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, hold-under-backpressure and bubble timing.
    int          post_hs = 0;  // 1: after non-last handshake, 3: after bubble, 2: after last
    logic        stall_prev = 1'b0;
    logic [95:0] hdr_prev;
    logic [9:0]  len_prev;
    logic        last_prev;
    cpl_t        got;

    always @(negedge clk_125) begin
        if (rst) begin
            post_hs    = 0;
            stall_prev = 1'b0;
        end else begin
            if (post_hs == 1) begin
                check("bubble_valid", cpl_valid, 0);
                post_hs = 3;
            end else if (post_hs == 3) begin
                check("resume_valid", cpl_valid, 1);
                post_hs = 0;
            end else if (post_hs == 2) begin
                check("ready_after_last", req_ready, 1);
                post_hs = 0;
            end
            if (stall_prev) begin
                check("hold_valid", cpl_valid, 1);
                check("hold_hdr", cpl_hdr, hdr_prev);
                check("hold_len", cpl_len, len_prev);
                check("hold_last", cpl_last, last_prev);
            end
            if (cpl_valid) check("busy_req_ready", req_ready, 0);
            if (cpl_valid && cpl_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cpl", cpl_valid, 0);
                end else begin
                    got = exp_q.pop_front();
                    check("cpl_hdr", cpl_hdr, got.hdr);
                    check("cpl_len", cpl_len, got.len);
                    check("cpl_last", cpl_last, got.last);
                end
                post_hs = cpl_last ? 2 : 1;
            end
            stall_prev = cpl_valid && !cpl_ready;
            hdr_prev   = cpl_hdr;
            len_prev   = cpl_len;
            last_prev  = cpl_last;
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached with %0d expected completions pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] h0;
        logic [9:0]  l0;
        logic [9:0]  ra;
        logic [9:0]  rl;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk_125);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_cpl_hdr", cpl_hdr, 0);
        check("rst_cpl_len", cpl_len, 0);
        check("rst_cpl_last", cpl_last, 0);
        rst = 1'b0;
        @(negedge clk_125);
        check("rel_req_ready", req_ready, 1);

        // Single-DW read
        send_req(10'h001, 10'd1, 5'h03, 16'h1234, 16'hABCD);
        check("one_dw_hdr", cpl_hdr, {32'h4A00_0001, 16'hABCD, 4'h0, 12'd4,
                                       16'h1234, 3'b000, 5'h03, 1'b0, 7'h04});
        check("one_dw_len", cpl_len, 1);
        check("one_dw_last", cpl_last, 1);
        wait_idle();

        // Two completions split at the MPS boundary
        send_req(10'h000, 10'd40, 5'h11, 16'h0100, 16'h0200);
        check("split40_bc", cpl_hdr[43:32], 12'd160);
        check("split40_len", cpl_len, 32);
        wait_idle();

        // Unaligned start
        send_req(10'h01C, 10'd10, 5'h1F, 16'hBEEF, 16'hCAFE);
        check("unal_bc", cpl_hdr[43:32], 12'd40);
        check("unal_la", cpl_hdr[6:0], 7'h70);
        check("unal_len", cpl_len, 4);
        wait_idle();

        // 1024-DW read: byte count of the first header wraps to 0
        send_req(10'h000, 10'd0, 5'h0A, 16'h5A5A, 16'hA5A5);
        check("full_bc", cpl_hdr[43:32], 12'd0);
        check("full_dw0", cpl_hdr[95:64], 32'h4A00_0020);
        wait_idle();

        // Backpressure with a request pulsed while busy
        rdy_mode = 2;
        send_req(10'h000, 10'd40, 5'h07, 16'h7777, 16'h8888);
        h0 = cpl_hdr;
        l0 = cpl_len;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_125); #1;
            if (i == 1) begin
                req_valid = 1'b1;
                req_addr  = 10'h155;
                req_len   = 10'd3;
                req_tag   = 5'h15;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk_125);
            check("bp_hdr", cpl_hdr, h0);
            check("bp_len", cpl_len, l0);
            check("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rdy_mode = 0;
        wait_idle();
        repeat (6) begin
            @(negedge clk_125);
            check("bp_no_extra", cpl_valid, 0);
        end

        // Reset in the middle of a two-completion request
        rdy_mode = 2;
        send_req(10'h000, 10'd40, 5'h02, 16'h2222, 16'h3333);
        @(posedge clk_125); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk_125); #1;
        check("midrst_valid", cpl_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk_125);
        check("midrst_rel_ready", req_ready, 1);
        repeat (10) begin
            @(negedge clk_125);
            check("midrst_no_resume", cpl_valid, 0);
        end

        // Randomized requests under random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 40; n++) begin
            ra = 10'($urandom_range(0, 1023));
            rl = ($urandom % 8 == 0) ? 10'd0 : 10'($urandom_range(1, 100));
            send_req(ra, rl, 5'($urandom), 16'($urandom), 16'($urandom));
        end
        wait_idle();
        rdy_mode = 0;
        repeat (4) @(negedge clk_125);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
